// File: rtl/spell_pkg.sv
// Shared definitions for the spell memory controller and any other bus master
// that needs the same address map or state encoding.
package spell_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IO_ACC  = 2'd1,
    RAM_ACC = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [7:0] IO_BASE_DEFAULT = 8'h20;
  localparam logic [7:0] IO_TOP_DEFAULT  = 8'h5F;
  localparam logic [7:0] ABORT_DATA      = 8'hFF;
  localparam int unsigned WAIT_W         = 4;

endpackage

// File: rtl/spell_addr_decode.sv
// Combinational address decode: flags addresses inside the IO window.
module spell_addr_decode
  import spell_pkg::*;
#(
  parameter logic [7:0] IO_BASE = IO_BASE_DEFAULT,
  parameter logic [7:0] IO_TOP  = IO_TOP_DEFAULT
) (
  input  logic [7:0] addr_i,
  output logic       is_io_o
);

  assign is_io_o = (addr_i >= IO_BASE) && (addr_i <= IO_TOP);

endmodule

// File: rtl/spell_mem_ctrl.sv
// CPU-side memory controller: routes one request at a time to the IO block or
// the data RAM, waits for the target's ready and aborts on a wait timeout.
module spell_mem_ctrl
  import spell_pkg::*;
#(
  parameter logic [7:0]  IO_BASE = IO_BASE_DEFAULT,
  parameter logic [7:0]  IO_TOP  = IO_TOP_DEFAULT,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_valid,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  input  logic       cpu_write,
  output logic [7:0] cpu_rdata,
  output logic       cpu_ready,
  output logic       io_select,
  output logic       io_write,
  output logic [7:0] io_addr,
  output logic [7:0] io_data_in,
  input  logic [7:0] io_data_out,
  input  logic       io_data_ready,
  output logic       ram_select,
  output logic       ram_write,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata,
  input  logic       ram_ready,
  output logic       bus_error
);

  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;

  logic       is_io;
  logic       tgt_ready;
  logic [7:0] tgt_rdata;

  spell_addr_decode #(
    .IO_BASE(IO_BASE),
    .IO_TOP (IO_TOP)
  ) u_decode (
    .addr_i (cpu_addr),
    .is_io_o(is_io)
  );

  // Only the currently selected target's response is looked at.
  always_comb begin
    tgt_ready = 1'b0;
    tgt_rdata = 8'h00;
    if (state_q == IO_ACC) begin
      tgt_ready = io_data_ready;
      tgt_rdata = io_data_out;
    end else if (state_q == RAM_ACC) begin
      tgt_ready = ram_ready;
      tgt_rdata = ram_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    wait_d  = wait_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_valid) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          write_d = cpu_write;
          wait_d  = '0;
          state_d = is_io ? IO_ACC : RAM_ACC;
        end
      end
      IO_ACC, RAM_ACC: begin
        // Ready wins over timeout when both land in the same cycle.
        if (tgt_ready) begin
          if (!write_q) rdata_d = tgt_rdata;
          state_d = DONE;
        end else if (wait_q == TIMEOUT_CNT) begin
          if (!write_q) rdata_d = ABORT_DATA;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      write_q <= 1'b0;
      rdata_q <= 8'h00;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign cpu_rdata  = rdata_q;
  assign cpu_ready  = (state_q == DONE);
  assign bus_error  = err_q;

  assign io_select  = (state_q == IO_ACC);
  assign io_write   = write_q;
  assign io_addr    = addr_q;
  assign io_data_in = wdata_q;

  assign ram_select = (state_q == RAM_ACC);
  assign ram_write  = write_q;
  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;

endmodule

// File: tb/tb_spell_mem_ctrl.sv
// Directed self-checking bench for spell_mem_ctrl with simple IO/RAM responders.
module tb_spell_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_valid = 1'b0;
  logic [7:0] cpu_addr = 8'h00;
  logic [7:0] cpu_wdata = 8'h00;
  logic       cpu_write = 1'b0;
  logic [7:0] cpu_rdata;
  logic       cpu_ready;
  logic       io_select, io_write;
  logic [7:0] io_addr, io_data_in;
  logic [7:0] io_data_out = 8'h00;
  logic       io_data_ready = 1'b0;
  logic       ram_select, ram_write;
  logic [7:0] ram_addr, ram_wdata;
  logic [7:0] ram_rdata = 8'h00;
  logic       ram_ready = 1'b0;
  logic       bus_error;

  int checks = 0;
  int errors = 0;

  // responder configuration: ready appears in select cycle (lat+1)
  int io_lat = 1000;
  int ram_lat = 1000;
  bit io_stray = 1'b0;
  int io_cnt = 0;
  int ram_cnt = 0;

  // monitor state
  int io_sel_cyc = 0, ram_sel_cyc = 0, io_eps = 0, rdy_pulses = 0, both_sel = 0;
  int io_unstable = 0, ram_unstable = 0;
  logic        prev_io_sel = 1'b0, prev_ram_sel = 1'b0;
  logic [16:0] prev_io_bus = '0, prev_ram_bus = '0;
  logic [7:0]  seen_ram_wdata = 8'h00;
  logic        seen_ram_write = 1'b0;

  spell_mem_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_valid    (cpu_valid),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_write    (cpu_write),
    .cpu_rdata    (cpu_rdata),
    .cpu_ready    (cpu_ready),
    .io_select    (io_select),
    .io_write     (io_write),
    .io_addr      (io_addr),
    .io_data_in   (io_data_in),
    .io_data_out  (io_data_out),
    .io_data_ready(io_data_ready),
    .ram_select   (ram_select),
    .ram_write    (ram_write),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .ram_ready    (ram_ready),
    .bus_error    (bus_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    io_cnt        <= io_select ? io_cnt + 1 : 0;
    ram_cnt       <= ram_select ? ram_cnt + 1 : 0;
    io_data_ready <= io_stray || (io_select && (io_cnt >= io_lat));
    ram_ready     <= ram_select && (ram_cnt >= ram_lat);
  end

  always @(negedge clk) begin
    if (io_select) io_sel_cyc <= io_sel_cyc + 1;
    if (ram_select) ram_sel_cyc <= ram_sel_cyc + 1;
    if (io_select && !prev_io_sel) io_eps <= io_eps + 1;
    if (cpu_ready) rdy_pulses <= rdy_pulses + 1;
    if (io_select && ram_select) both_sel <= both_sel + 1;
    if (io_select && prev_io_sel && ({io_addr, io_data_in, io_write} !== prev_io_bus))
      io_unstable <= io_unstable + 1;
    if (ram_select && prev_ram_sel && ({ram_addr, ram_wdata, ram_write} !== prev_ram_bus))
      ram_unstable <= ram_unstable + 1;
    prev_io_sel  <= io_select;
    prev_ram_sel <= ram_select;
    prev_io_bus  <= {io_addr, io_data_in, io_write};
    prev_ram_bus <= {ram_addr, ram_wdata, ram_write};
    if (ram_select) begin
      seen_ram_wdata <= ram_wdata;
      seen_ram_write <= ram_write;
    end
  end

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  // Issue one request; lat = negedges until cpu_ready seen (-1 if never).
  task automatic do_access(input logic [7:0] a, input logic [7:0] wd, input logic wr,
                           input bit scramble, output logic [7:0] rd, output int lat);
    cpu_addr = a; cpu_wdata = wd; cpu_write = wr; cpu_valid = 1'b1;
    lat = -1; rd = 8'hxx;
    for (int k = 1; k <= 40; k++) begin
      wait_neg();
      if (scramble && k == 1) begin
        cpu_addr = ~a; cpu_wdata = 8'hEE; cpu_write = ~wr;
      end
      if (cpu_ready) begin
        lat = k; rd = cpu_rdata;
        break;
      end
    end
    cpu_valid = 1'b0;
    $display("access addr=%02h wr=%0d wdata=%02h -> rdata=%02h lat=%0d err=%0d", a, wr, wd, rd, lat, bus_error);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) wait_neg();
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_cpu_ready got %0h exp 0", cpu_ready); end
    checks++; if ({io_select, ram_select} !== 2'b00) begin errors++; $display("FAIL reset_selects got %b exp 00", {io_select, ram_select}); end
    checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %02h exp 00", cpu_rdata); end
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL reset_bus_error got %0h exp 0", bus_error); end
    checks++; if ({io_addr, io_data_in, io_write} !== 17'h0) begin errors++; $display("FAIL reset_latched got %05h exp 00000", {io_addr, io_data_in, io_write}); end
    rst = 1'b0;
    wait_neg();
  endtask

  task automatic test_io_read();
    logic [7:0] rd; int lat; int s_io, s_ram, s_rdy, s_un;
    io_lat = 1; ram_lat = 1000; io_data_out = 8'hA5;
    s_io = io_sel_cyc; s_ram = ram_sel_cyc; s_rdy = rdy_pulses; s_un = io_unstable;
    do_access(8'h38, 8'h00, 1'b0, 1'b1, rd, lat);
    wait_neg();
    checks++; if (lat !== 3) begin errors++; $display("FAIL io_read_latency got %0d exp 3", lat); end
    checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL io_read_rdata got %02h exp a5", rd); end
    checks++; if (io_sel_cyc - s_io !== 2) begin errors++; $display("FAIL io_read_sel_cycles got %0d exp 2", io_sel_cyc - s_io); end
    checks++; if (ram_sel_cyc - s_ram !== 0) begin errors++; $display("FAIL io_read_ram_sel got %0d exp 0", ram_sel_cyc - s_ram); end
    checks++; if (rdy_pulses - s_rdy !== 1) begin errors++; $display("FAIL io_read_pulses got %0d exp 1", rdy_pulses - s_rdy); end
    checks++; if (io_unstable - s_un !== 0) begin errors++; $display("FAIL io_read_bus_stable got %0d changes exp 0", io_unstable - s_un); end
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL io_read_bus_error got %0h exp 0", bus_error); end
    checks++; if (cpu_rdata !== 8'hA5 || io_addr !== 8'h38) begin errors++; $display("FAIL io_read_hold got rdata=%02h addr=%02h exp a5 38", cpu_rdata, io_addr); end
  endtask

  task automatic test_ram_write();
    logic [7:0] rd; int lat; int s_io, s_ram, s_rdy, s_un;
    io_stray = 1'b1; ram_lat = 3; ram_rdata = 8'h5D;
    wait_neg();
    s_io = io_sel_cyc; s_ram = ram_sel_cyc; s_rdy = rdy_pulses; s_un = ram_unstable;
    do_access(8'h80, 8'h3C, 1'b1, 1'b1, rd, lat);
    wait_neg();
    io_stray = 1'b0;
    checks++; if (lat !== 5) begin errors++; $display("FAIL ram_write_latency got %0d exp 5", lat); end
    checks++; if (ram_sel_cyc - s_ram !== 4) begin errors++; $display("FAIL ram_write_sel_cycles got %0d exp 4", ram_sel_cyc - s_ram); end
    checks++; if (io_sel_cyc - s_io !== 0) begin errors++; $display("FAIL ram_write_io_sel got %0d exp 0", io_sel_cyc - s_io); end
    checks++; if (rdy_pulses - s_rdy !== 1) begin errors++; $display("FAIL ram_write_pulses got %0d exp 1", rdy_pulses - s_rdy); end
    checks++; if (ram_unstable - s_un !== 0) begin errors++; $display("FAIL ram_write_bus_stable got %0d changes exp 0", ram_unstable - s_un); end
    checks++; if ({seen_ram_write, seen_ram_wdata} !== 9'h13C) begin errors++; $display("FAIL ram_write_data got wr=%0h wdata=%02h exp 1 3c", seen_ram_write, seen_ram_wdata); end
    checks++; if (cpu_rdata !== 8'hA5) begin errors++; $display("FAIL ram_write_rdata_kept got %02h exp a5", cpu_rdata); end
  endtask

  task automatic test_boundaries();
    logic [7:0] baddr [4] = '{8'h1F, 8'h20, 8'h5F, 8'h60};
    bit         bio   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] rd; int lat; int s_io, s_ram;
    io_lat = 1; ram_lat = 1;
    for (int i = 0; i < 4; i++) begin
      s_io = io_sel_cyc; s_ram = ram_sel_cyc;
      do_access(baddr[i], 8'h00, 1'b0, 1'b0, rd, lat);
      wait_neg();
      checks++; if ((io_sel_cyc - s_io !== (bio[i] ? 2 : 0)) || (ram_sel_cyc - s_ram !== (bio[i] ? 0 : 2)))
        begin errors++; $display("FAIL boundary_%02h got io=%0d ram=%0d exp io_target=%0d", baddr[i], io_sel_cyc - s_io, ram_sel_cyc - s_ram, bio[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] baddr [3] = '{8'h21, 8'h22, 8'h23};
    logic [7:0] bdata [3] = '{8'h11, 8'h22, 8'h33};
    int         bk    [3] = '{3, 7, 11};
    int pk [3] = '{-1, -1, -1};
    logic [7:0] pd [3] = '{8'hxx, 8'hxx, 8'hxx};
    int n = 0; int s_rdy, s_eps;
    io_lat = 1;
    s_rdy = rdy_pulses; s_eps = io_eps;
    cpu_addr = baddr[0]; io_data_out = bdata[0]; cpu_write = 1'b0; cpu_valid = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      wait_neg();
      if (cpu_ready) begin
        pk[n] = k; pd[n] = cpu_rdata;
        $display("b2b pulse %0d at cycle %0d rdata=%02h", n, k, cpu_rdata);
        n++;
        if (n == 3) break;
        cpu_addr = baddr[n]; io_data_out = bdata[n];
      end
    end
    cpu_valid = 1'b0;
    repeat (6) wait_neg();
    for (int i = 0; i < 3; i++) begin
      checks++; if (pk[i] !== bk[i] || pd[i] !== bdata[i])
        begin errors++; $display("FAIL b2b_access%0d got cycle=%0d data=%02h exp cycle=%0d data=%02h", i, pk[i], pd[i], bk[i], bdata[i]); end
    end
    checks++; if (rdy_pulses - s_rdy !== 3 || io_eps - s_eps !== 3)
      begin errors++; $display("FAIL b2b_counts got pulses=%0d selects=%0d exp 3 3", rdy_pulses - s_rdy, io_eps - s_eps); end
  endtask

  task automatic test_timeout();
    logic [7:0] rd; int lat; int s_ram;
    ram_lat = 1000;
    s_ram = ram_sel_cyc;
    do_access(8'h90, 8'h00, 1'b0, 1'b0, rd, lat);
    wait_neg();
    checks++; if (lat !== 17) begin errors++; $display("FAIL timeout_latency got %0d exp 17", lat); end
    checks++; if (rd !== 8'hFF) begin errors++; $display("FAIL timeout_rdata got %02h exp ff", rd); end
    checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL timeout_bus_error got %0h exp 1", bus_error); end
    checks++; if (ram_sel_cyc - s_ram !== 16) begin errors++; $display("FAIL timeout_sel_cycles got %0d exp 16", ram_sel_cyc - s_ram); end
    io_lat = 1; io_data_out = 8'h5C;
    do_access(8'h40, 8'h00, 1'b0, 1'b0, rd, lat);
    wait_neg();
    checks++; if (rd !== 8'h5C) begin errors++; $display("FAIL after_timeout_rdata got %02h exp 5c", rd); end
    checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL sticky_bus_error got %0h exp 1", bus_error); end
  endtask

  task automatic test_reset_mid();
    int s_rdy;
    io_lat = 1000;
    cpu_addr = 8'h40; cpu_write = 1'b0; cpu_valid = 1'b1;
    repeat (2) wait_neg();
    checks++; if (io_select !== 1'b1) begin errors++; $display("FAIL rst_mid_in_access got %0h exp 1", io_select); end
    s_rdy = rdy_pulses;
    rst = 1'b1; cpu_valid = 1'b0;
    wait_neg();
    $display("reset pulsed during IO access");
    checks++; if ({io_select, ram_select, cpu_ready} !== 3'b000) begin errors++; $display("FAIL rst_mid_ctrl got %b exp 000", {io_select, ram_select, cpu_ready}); end
    checks++; if ({bus_error, cpu_rdata, io_addr} !== 17'h0) begin errors++; $display("FAIL rst_mid_values got err=%0h rdata=%02h addr=%02h exp 0 00 00", bus_error, cpu_rdata, io_addr); end
    rst = 1'b0;
    repeat (5) wait_neg();
    checks++; if (rdy_pulses - s_rdy !== 0 || io_select !== 1'b0) begin errors++; $display("FAIL rst_mid_no_pulse got pulses=%0d sel=%0h exp 0 0", rdy_pulses - s_rdy, io_select); end
  endtask

  task automatic test_ready_at_timeout();
    logic [7:0] rd; int lat;
    ram_lat = 15; ram_rdata = 8'h77;
    do_access(8'h85, 8'h00, 1'b0, 1'b0, rd, lat);
    wait_neg();
    checks++; if (lat !== 17 || rd !== 8'h77) begin errors++; $display("FAIL ready_at_timeout got lat=%0d rdata=%02h exp 17 77", lat, rd); end
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL ready_at_timeout_err got %0h exp 0", bus_error); end
  endtask

  initial begin
    test_reset();
    test_io_read();
    test_ram_write();
    test_boundaries();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_ready_at_timeout();
    checks++; if (both_sel !== 0) begin errors++; $display("FAIL both_selects got %0d cycles exp 0", both_sel); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
